// File: rtl/tdm_demux4_pkg.sv
// Constants and lane-packing rule shared between the TDM lane mux and demux.
package tdm_demux4_pkg;

    localparam int TDM_LANES  = 4;
    localparam int TDM_SLOT_W = 2;

    // Lane i of a packed frame occupies bits [width*(i+1)-1 : width*i].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/lane_wr_dec.sv
// Slot decoder: turns (slot counter, din_valid, frame_sync) into lane write
// strobes, a frame-complete strobe (lane 3 slot) and a misaligned-sync flag.
module lane_wr_dec
    import tdm_demux4_pkg::*;
(
    input  logic [TDM_SLOT_W-1:0] cnt,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [TDM_LANES-2:0]  lane_we,
    output logic                  frame_done,
    output logic                  sync_miss
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no latch is inferred.
        lane_we    = '0;
        frame_done = 1'b0;
        sync_miss  = 1'b0;
        if (din_valid) begin
            if (frame_sync) begin
                lane_we[0] = 1'b1;
                sync_miss  = (cnt != '0);
            end else if (cnt == TDM_SLOT_W'(TDM_LANES - 1)) begin
                // Lane 3 has no register; its slot completes the frame.
                frame_done = 1'b1;
            end else begin
                lane_we[cnt] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer: steers samples into lane registers and
// hands a complete frame to the consumer through a valid/ready output slot.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [4*WIDTH-1:0]     out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sync_err,
    output logic                   overflow
);

    logic [TDM_SLOT_W-1:0] cnt;
    logic [WIDTH-1:0]      lane [TDM_LANES-1];
    logic [TDM_LANES-2:0]  lane_we;
    logic                  frame_done;
    logic                  sync_miss;
    logic                  slot_free;

    lane_wr_dec u_dec (
        .cnt        (cnt),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .lane_we    (lane_we),
        .frame_done (frame_done),
        .sync_miss  (sync_miss)
    );

    // The output slot can take a new frame if empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < TDM_LANES - 1; i++) lane[i] <= '0;
        end else begin
            sync_err <= sync_miss;

            if (din_valid) cnt <= frame_sync ? TDM_SLOT_W'(1) : cnt + 1'b1;

            for (int i = 0; i < TDM_LANES - 1; i++)
                if (lane_we[i]) lane[i] <= din;

            if (frame_done) begin
                if (slot_free) begin
                    out_data[lane_lsb(TDM_LANES - 1, WIDTH) +: WIDTH] <= din;
                    for (int i = 0; i < TDM_LANES - 1; i++)
                        out_data[lane_lsb(i, WIDTH) +: WIDTH] <= lane[i];
                    out_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios followed by random
// traffic, compared against a frame-level reference model.
module tb_tdm_demux4;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           frame_sync = 1'b0;
    logic [4*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           sync_err;
    logic           overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: samples of the frame in progress, plus the output slot.
    logic [W-1:0]   part[$];
    logic [4*W-1:0] exp_data = '0;
    logic           exp_valid = 1'b0;
    logic           exp_serr = 1'b0;
    logic           exp_ovf = 1'b0;

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sync_err   (sync_err),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [W-1:0] d, input logic v, input logic s, input logic r);
        logic           done;
        logic [4*W-1:0] frame;
        done     = 1'b0;
        frame    = '0;
        exp_serr = 1'b0;
        if (v) begin
            if (s && part.size() != 0) begin
                exp_serr = 1'b1;
                part.delete();
            end
            part.push_back(d);
            if (part.size() == 4) begin
                frame = {part[3], part[2], part[1], part[0]};
                part.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!exp_valid || r) begin
                exp_valid = 1'b1;
                exp_data  = frame;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (exp_valid && r) begin
            exp_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, then sample outputs 1 time unit after the edge.
    task automatic cycle(input logic [W-1:0] d, input logic v, input logic s, input logic r);
        din = d; din_valid = v; frame_sync = s; out_ready = r;
        model_step(d, v, s, r);
        @(posedge clk); #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_data",  out_data, exp_data);
        check("sync_err",  32'(sync_err), 32'(exp_serr));
        check("overflow",  32'(overflow), 32'(exp_ovf));
    endtask

    task automatic idle(input logic r);
        cycle('0, 1'b0, 1'b0, r);
    endtask

    task automatic model_reset();
        part.delete();
        exp_data = '0; exp_valid = 1'b0; exp_serr = 1'b0; exp_ovf = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_out_data",  out_data, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sync_err",  32'(sync_err), 32'h0);
        check("rst_overflow",  32'(overflow), 32'h0);
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    initial begin
        // Initial reset, released away from a clock edge.
        @(posedge clk); #1;
        pulse_reset();
        idle(1'b0);

        // Aligned frame.
        cycle(8'h11, 1, 1, 0);
        cycle(8'h22, 1, 0, 0);
        cycle(8'h33, 1, 0, 0);
        cycle(8'h44, 1, 0, 0);
        check("aligned_frame", out_data, 32'h44332211);
        check("aligned_valid", 32'(out_valid), 32'h1);
        idle(1'b1);
        check("aligned_drained", 32'(out_valid), 32'h0);

        // Back-to-back frames with the consumer always ready.
        cycle(8'h11, 1, 1, 1);
        cycle(8'h22, 1, 0, 1);
        cycle(8'h33, 1, 0, 1);
        cycle(8'h44, 1, 0, 1);
        check("b2b_first", out_data, 32'h44332211);
        cycle(8'h55, 1, 1, 1);
        cycle(8'h66, 1, 0, 1);
        cycle(8'h77, 1, 0, 1);
        cycle(8'h88, 1, 0, 1);
        check("b2b_second", out_data, 32'h88776655);
        check("b2b_no_overflow", 32'(overflow), 32'h0);
        idle(1'b1);

        // Backpressure: second frame is dropped and overflow sticks.
        cycle(8'h11, 1, 1, 0);
        cycle(8'h22, 1, 0, 0);
        cycle(8'h33, 1, 0, 0);
        cycle(8'h44, 1, 0, 0);
        cycle(8'h55, 1, 1, 0);
        cycle(8'h66, 1, 0, 0);
        cycle(8'h77, 1, 0, 0);
        cycle(8'h88, 1, 0, 0);
        check("bp_held", out_data, 32'h44332211);
        check("bp_overflow", 32'(overflow), 32'h1);
        idle(1'b1);
        check("bp_drop_valid", 32'(out_valid), 32'h0);
        check("bp_overflow_sticky", 32'(overflow), 32'h1);

        // Misaligned sync restarts the frame at CC.
        pulse_reset();
        cycle(8'hAA, 1, 1, 1);
        cycle(8'hBB, 1, 0, 1);
        cycle(8'hCC, 1, 1, 1);
        check("mis_sync_err", 32'(sync_err), 32'h1);
        cycle(8'hDD, 1, 0, 1);
        check("mis_sync_err_clear", 32'(sync_err), 32'h0);
        cycle(8'hEE, 1, 0, 1);
        cycle(8'hFF, 1, 0, 1);
        check("mis_frame", out_data, 32'hFFEEDDCC);
        idle(1'b1);

        // Gapped input yields the same frame one clock after the last sample.
        cycle(8'h11, 1, 1, 0);
        idle(1'b0);
        cycle(8'h22, 1, 0, 0);
        idle(1'b0);
        idle(1'b0);
        cycle(8'h33, 1, 0, 0);
        idle(1'b0);
        cycle(8'h44, 1, 0, 0);
        check("gap_frame", out_data, 32'h44332211);
        check("gap_valid", 32'(out_valid), 32'h1);
        idle(1'b1);

        // Asynchronous reset mid-frame, then a frame without any sync.
        cycle(8'h99, 1, 1, 0);
        cycle(8'h98, 1, 0, 0);
        #2;
        pulse_reset();
        cycle(8'hA1, 1, 0, 0);
        cycle(8'hB2, 1, 0, 0);
        cycle(8'hC3, 1, 0, 0);
        cycle(8'hD4, 1, 0, 0);
        check("post_rst_frame", out_data, 32'hD4C3B2A1);
        idle(1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle(W'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
